// File: rtl/skadd_pkg.sv
// -----------------------------------------------------------------------------
// skadd_pkg
// Shared types and helpers for the pipelined Sklansky adder.
//
// Contents:
//   gp_t        - one (generate, propagate) pair of the prefix tree
//   clog2       - ceiling log2 usable in constant expressions
//   calc_nbank  - number of register banks for a given depth / spacing
//   DEF_*       - derived constants for the default 16-bit, 2-level build
// -----------------------------------------------------------------------------
package skadd_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Banks sit after every reg_every levels; the last one may cover fewer.
    function automatic int calc_nbank(input int log2w, input int reg_every);
        return (log2w + reg_every - 1) / reg_every;
    endfunction

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_REG_EVERY = 2;
    localparam int DEF_LOG2W     = clog2(DEF_WIDTH);
    localparam int DEF_NBANK     = calc_nbank(DEF_LOG2W, DEF_REG_EVERY);
    localparam int DEF_NSTG      = DEF_NBANK + 1;

endpackage

// File: rtl/sklansky_level.sv
// -----------------------------------------------------------------------------
// sklansky_level
// One purely combinational level of a Sklansky prefix tree.
//
// Parameters:
//   WIDTH - number of bit positions
//   LEVEL - prefix level index (0 .. log2(WIDTH)-1)
//
// Ports:
//   gp_in  - (G,P) group pairs entering this level
//   gp_out - (G,P) group pairs leaving this level
// -----------------------------------------------------------------------------
module sklansky_level
    import skadd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 0
) (
    input  gp_t [WIDTH-1:0] gp_in,
    output gp_t [WIDTH-1:0] gp_out
);

    // A bit whose LEVEL-th index bit is set absorbs the group that ends just
    // below its aligned 2^LEVEL block; all other bits pass straight through.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i >> LEVEL) % 2) == 1) begin : g_comb
            localparam int J = ((i >> LEVEL) << LEVEL) - 1;
            assign gp_out[i].g = gp_in[i].g | (gp_in[i].p & gp_in[J].g);
            assign gp_out[i].p = gp_in[i].p & gp_in[J].p;
        end else begin : g_pass
            assign gp_out[i] = gp_in[i];
        end
    end

endmodule

// File: rtl/sklansky_pipe_adder.sv
// -----------------------------------------------------------------------------
// sklansky_pipe_adder
// Pipelined, parametrised Sklansky parallel-prefix adder with valid/ready
// handshakes on both sides. One add per clock when the sink is ready.
//
// Parameters:
//   WIDTH     - operand width, power of two, 4..128
//   REG_EVERY - prefix levels between register banks, 1..log2(WIDTH)
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready - operand handshake (a, b, ci)
//   a, b, ci            - operands and carry in
//   out_valid/out_ready - result handshake
//   s, co               - sum and carry out, driven from the last register
//   ovf                 - signed overflow (only when SKADD_OVF_EN is defined)
//
// Build option:
//   SKADD_OVF_EN - adds the ovf output, pipelined alongside s.
//
// Stage 0 holds g/p/ci, banks 1..NBANK-1 hold intermediate prefix vectors,
// and the final stage holds s/co, giving NBANK+1 stages in total.
// -----------------------------------------------------------------------------
module sklansky_pipe_adder
    import skadd_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SKADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int LOG2W = clog2(WIDTH);
    localparam int NBANK = calc_nbank(LOG2W, REG_EVERY);
    localparam int NSTG  = NBANK + 1;

    typedef gp_t [WIDTH-1:0] gp_vec_t;

    logic [NSTG-1:0]  v;
    logic [NSTG-1:0]  load;

    logic [WIDTH-1:0] g0_q;
    logic [WIDTH-1:0] p0_q;
    logic             ci0_q;
    gp_vec_t          gp_fold;

    gp_vec_t          gp_last;
    logic [WIDTH-1:0] p_last;
    logic             ci_last;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_d;
    logic             unused_gp_p;

    // A stage may load when it is empty or when everything downstream of it
    // can move. Unrolled from the output backwards so no vector feeds itself.
    always_comb begin
        logic chain;
        load  = '0;
        chain = out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            chain   = chain | ~v[k];
            load[k] = chain;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v[NSTG-1];

    // Stage valid bits; a bubble is overwritten as soon as the next item
    // arrives, so gaps collapse instead of travelling to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            if (load[0]) begin
                v[0] <= in_valid;
            end
            for (int k = 1; k < NSTG; k++) begin
                if (load[k]) begin
                    v[k] <= v[k-1];
                end
            end
        end
    end

    // Stage 0 captures raw generate/propagate and the carry in.
    always_ff @(posedge clk) begin
        if (load[0] && in_valid) begin
            g0_q  <= a & b;
            p0_q  <= a ^ b;
            ci0_q <= ci;
        end
    end

    // The carry in acts as a generate at position -1; merging it into bit 0
    // here means the tree needs no extra level for it. Bit 0's group P then
    // covers position -1, whose propagate is zero.
    always_comb begin
        gp_fold = '0;
        for (int i = 0; i < WIDTH; i++) begin
            gp_fold[i].g = g0_q[i];
            gp_fold[i].p = p0_q[i];
        end
        gp_fold[0].g = g0_q[0] | (p0_q[0] & ci0_q);
        gp_fold[0].p = 1'b0;
    end

    // Prefix levels. Each level knows where its input comes from (stage 0,
    // a register bank, or the previous level) and carries the original
    // propagate vector and carry in alongside for the final sum.
    for (genvar l = 0; l < LOG2W; l++) begin : g_lvl
        gp_vec_t          lin;
        gp_vec_t          lout;
        logic [WIDTH-1:0] p_cur;
        logic             ci_cur;

        if (l == 0) begin : g_src
            assign lin    = gp_fold;
            assign p_cur  = p0_q;
            assign ci_cur = ci0_q;
        end else if ((l % REG_EVERY) == 0) begin : g_src
            assign lin    = g_lvl[l-1].g_bank.gp_r;
            assign p_cur  = g_lvl[l-1].g_bank.p_r;
            assign ci_cur = g_lvl[l-1].g_bank.ci_r;
        end else begin : g_src
            assign lin    = g_lvl[l-1].lout;
            assign p_cur  = g_lvl[l-1].p_cur;
            assign ci_cur = g_lvl[l-1].ci_cur;
        end

        sklansky_level #(
            .WIDTH (WIDTH),
            .LEVEL (l)
        ) u_level (
            .gp_in  (lin),
            .gp_out (lout)
        );

        // Register bank K after this level; the last level instead feeds
        // the sum logic, which registers into the output stage.
        if ((((l + 1) % REG_EVERY) == 0) && (l != LOG2W - 1)) begin : g_bank
            localparam int K = (l + 1) / REG_EVERY;
            gp_vec_t          gp_r;
            logic [WIDTH-1:0] p_r;
            logic             ci_r;

            always_ff @(posedge clk) begin
                if (load[K] && v[K-1]) begin
                    gp_r <= lout;
                    p_r  <= p_cur;
                    ci_r <= ci_cur;
                end
            end
        end
    end

    assign gp_last = g_lvl[LOG2W-1].lout;
    assign p_last  = g_lvl[LOG2W-1].p_cur;
    assign ci_last = g_lvl[LOG2W-1].ci_cur;

    // After the full tree each G is the carry out of its bit position.
    // The group propagates are not needed for the sum.
    always_comb begin
        carry       = '0;
        unused_gp_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i]    = gp_last[i].g;
            unused_gp_p = unused_gp_p ^ gp_last[i].p;
        end
    end

    assign sum_d = p_last ^ {carry[WIDTH-2:0], ci_last};

    // Output stage: reset so that s/co read zero while nothing is valid, and
    // held whenever the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s  <= '0;
            co <= 1'b0;
        end else if (load[NSTG-1] && v[NSTG-2]) begin
            s  <= sum_d;
            co <= carry[WIDTH-1];
        end
    end

`ifdef SKADD_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (load[NSTG-1] && v[NSTG-2]) begin
            ovf <= carry[WIDTH-1] ^ carry[WIDTH-2];
        end
    end
`endif

endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_sklansky_pipe_adder
// Scoreboard bench for sklansky_pipe_adder (WIDTH=16, REG_EVERY=2).
// Stimulus pushes the arithmetic result of a+b+ci into a queue; a monitor
// compares every presented result against the queue head and pops it on a
// handshake. Honours SKADD_OVF_EN by also checking ovf.
// -----------------------------------------------------------------------------
module tb_sklansky_pipe_adder;

    localparam int WIDTH     = 16;
    localparam int REG_EVERY = 2;
    localparam int LOG2W     = $clog2(WIDTH);
    localparam int NSTG      = (LOG2W + REG_EVERY - 1) / REG_EVERY + 1;
    localparam int TIMEOUT   = 1000;
    localparam int NDIR      = 9;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ovf;
        int               acc_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef SKADD_OVF_EN
    logic             ovf;
`endif

    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    bit   lat_check  = 1'b0;
    bit   rand_ready = 1'b0;
    logic ready_cmd  = 1'b0;
    exp_t sb_q[$];

    logic [WIDTH-1:0] dir_a [NDIR] = '{16'h59DF, 16'hCF42, 16'hD53C, 16'h1DF6,
                                       16'hFFFF, 16'h0000, 16'h7FFF, 16'hD53C,
                                       16'h8000};
    logic [WIDTH-1:0] dir_b [NDIR] = '{16'hBCD6, 16'h488D, 16'hC1C0, 16'hFD7A,
                                       16'h0000, 16'h0000, 16'h0001, 16'hC1C0,
                                       16'h8000};
    logic             dir_c [NDIR] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                       1'b0, 1'b1, 1'b0};

    sklansky_pipe_adder #(
        .WIDTH     (WIDTH),
        .REG_EVERY (REG_EVERY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
`ifdef SKADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink readiness changes shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end

    // Reference: plain integer addition, and signed overflow as "result does
    // not fit in a WIDTH-bit two's complement number".
    function automatic exp_t modelAdd(input logic [WIDTH-1:0] av,
                                      input logic [WIDTH-1:0] bv,
                                      input logic civ, input int acc);
        exp_t                    e;
        logic [WIDTH:0]          total;
        logic signed [WIDTH+1:0] ssum;
        logic signed [WIDTH+1:0] smax;
        logic signed [WIDTH+1:0] smin;
        total = (WIDTH+1)'(av) + (WIDTH+1)'(bv) + (WIDTH+1)'(civ);
        ssum  = (WIDTH+2)'($signed(av)) + (WIDTH+2)'($signed(bv)) + (WIDTH+2)'(civ);
        smax  = ((WIDTH+2)'(1) << (WIDTH-1)) - (WIDTH+2)'(1);
        smin  = -smax - (WIDTH+2)'(1);
        e.s       = total[WIDTH-1:0];
        e.co      = total[WIDTH];
        e.ovf     = (ssum > smax) || (ssum < smin);
        e.acc_cyc = acc;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] randOperand();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH:0] actual,
                               input logic [WIDTH:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    // Drives one operand set and waits (bounded) for it to be accepted.
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic civ);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        ci       = civ;
        for (int n = 0; n < TIMEOUT && !accepted; n++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                sb_q.push_back(modelAdd(av, bv, civ, cyc));
            end
        end
        if (!accepted) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL accept_timeout: actual in_ready 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 4 * TIMEOUT && sb_q.size() != 0; n++) @(negedge clk);
        checkOutput("drain_empty", (WIDTH+1)'(sb_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented result must match the queue head; the head is
    // retired only when the sink takes it, so stalled data is re-checked.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("[TB] FAIL unexpected_output: actual s=%0h, required no output", s);
            end else begin
                checkOutput("sum", (WIDTH+1)'(s), (WIDTH+1)'(sb_q[0].s));
                checkOutput("carry_out", (WIDTH+1)'(co), (WIDTH+1)'(sb_q[0].co));
`ifdef SKADD_OVF_EN
                checkOutput("overflow", (WIDTH+1)'(ovf), (WIDTH+1)'(sb_q[0].ovf));
`endif
                if (out_ready) begin
                    if (lat_check) begin
                        checkOutput("latency", (WIDTH+1)'(cyc - sb_q[0].acc_cyc),
                                    (WIDTH+1)'(NSTG));
                    end
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        exp_t first;
        bit   seen;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        ci       = 1'b0;

        // Reset state.
        #12;
        checkOutput("reset_out_valid", (WIDTH+1)'(out_valid), '0);
        checkOutput("reset_s", (WIDTH+1)'(s), '0);
        checkOutput("reset_co", (WIDTH+1)'(co), '0);
        checkOutput("reset_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
        @(negedge clk);
        rst_n     = 1'b1;
        ready_cmd = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back directed operands, no backpressure, latency checked.
        $display("[TB] directed back-to-back");
        lat_check = 1'b1;
        for (int i = 0; i < NDIR; i++) applyStimulus(dir_a[i], dir_b[i], dir_c[i]);
        drain();
        lat_check = 1'b0;

        // Backpressure: fill the pipe while the sink is stalled.
        $display("[TB] backpressure");
        ready_cmd = 1'b0;
        first     = modelAdd(dir_a[0], dir_b[0], dir_c[0], 0);
        for (int i = 0; i < 3; i++) applyStimulus(dir_a[i], dir_b[i], dir_c[i]);
        in_valid = 1'b1;
        a        = dir_a[3];
        b        = dir_b[3];
        ci       = dir_c[3];
        repeat (4) begin
            @(negedge clk);
            checkOutput("full_in_ready", (WIDTH+1)'(in_ready), '0);
            checkOutput("held_out_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(1));
            checkOutput("held_sum", (WIDTH+1)'(s), (WIDTH+1)'(first.s));
        end
        @(posedge clk);
        #1;
        ready_cmd = 1'b1;
        applyStimulus(dir_a[3], dir_b[3], dir_c[3]);
        drain();

        // Reset with results in flight.
        $display("[TB] reset mid-operation");
        ready_cmd = 1'b0;
        applyStimulus(dir_a[0], dir_b[0], dir_c[0]);
        applyStimulus(dir_a[1], dir_b[1], dir_c[1]);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checkOutput("prereset_out_valid", (WIDTH+1)'(seen), (WIDTH+1)'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", (WIDTH+1)'(out_valid), '0);
        checkOutput("async_s", (WIDTH+1)'(s), '0);
        checkOutput("async_co", (WIDTH+1)'(co), '0);
        checkOutput("async_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
        sb_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        ready_cmd = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("idle_after_reset", (WIDTH+1)'(out_valid), '0);
        end
        @(posedge clk);
        #1;
        lat_check = 1'b1;
        applyStimulus(dir_a[2], dir_b[2], dir_c[2]);
        drain();

        // Random operands with gaps, sink always ready, latency checked.
        $display("[TB] random, sink ready");
        for (int i = 0; i < 300; i++) begin
            applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        lat_check = 1'b0;

        // Random operands with random sink readiness.
        $display("[TB] random, random sink");
        rand_ready = 1'b1;
        for (int i = 0; i < 700; i++) begin
            applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sklansky_pipe_adder.md
Name: sklansky_pipe_adder

Overview:
- Parametrised, pipelined Sklansky parallel-prefix adder with valid/ready handshakes on input and output.
- Next generation of the team's fixed 16-bit combinational Sklansky adder:
  - operand width is configurable
  - pipeline register banks are inserted every REG_EVERY prefix levels
  - backpressure is supported without data loss
- Sits in datapaths that need one add per clock at high frequency.

Parameters:
- WIDTH, 16: operand width in bits. Power of two, 4..128.
- REG_EVERY, 2: number of prefix levels between register banks, 1..LOG2W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, ci are valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A (unsigned; two's complement if overflow enabled)
- b  input  WIDTH  operand B
- ci  input  1  carry in
- out_valid  output  1  s/co hold a valid result
- out_ready  input  1  downstream accepts the result
- s  output  WIDTH  sum bits [WIDTH-1:0]
- co  output  1  carry out

Behaviour:
- Derived constants:
  - LOG2W = log2(WIDTH)
  - NBANK = ceil(LOG2W/REG_EVERY)
  - NSTG = NBANK+1 register stages
  - Latency = NSTG cycles from accept (in_valid&in_ready) to out_valid, when there is no backpressure.
- Stage 0:
  - Registers bitwise g=a&b, p=a^b and ci.
  - ci is folded in as prefix position -1, so co and s[0] use it with no extra level.
- Prefix levels, l=0..LOG2W-1:
  - Standard Sklansky structure.
  - Bit i combines with the group ending at bit (i>>l<<l)-1 whenever bit l of i is set.
  - Combine rule: (G,P) = (Gh | Ph&Gl, Ph&Pl).
  - A register bank follows every REG_EVERY levels. The last bank may span fewer levels.
  - The original p vector is carried alongside through every bank.
- Final stage:
  - s[i] = p[i] ^ C[i-1], with C[-1] = ci.
  - co = C[WIDTH-1].
  - The final-stage combinational logic is inside the last bank's cone. s and co are driven directly from the last register stage.
- Handshake:
  - Each stage k has a valid bit v[k].
  - load[k] = !v[k] | load[k+1]; for the last stage, load = !v[last] | out_ready.
  - in_ready = load[0], which is combinational from out_ready through the stage valids.
  - Bubbles collapse, so throughput is 1 per cycle when out_ready=1.
  - While out_valid=1 and out_ready=0, s and co are held stable.
  - A stage that is not loaded holds its data.
  - out_valid = v[last].
- Arithmetic: the result is exactly (a+b+ci) mod 2^(WIDTH+1), split as {co,s}. No saturation.
- Reset:
  - Asynchronous. All v[k] clear to 0.
  - out_valid=0, s=0, co=0.
  - in_ready is 1 immediately after reset.
  - Reset mid-operation discards all in-flight results; nothing is emitted after deassertion.
  - Data registers other than the final stage need not be reset.
- Boundary conditions:
  - in_valid with in_ready=0: no capture. The source must hold its operands stable.
  - Simultaneous accept and emit (pipeline full, out_ready=1): both occur in the same cycle.
  - REG_EVERY >= LOG2W gives NSTG=2.

Optional Feature:
- Macro: SKADD_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), pipelined with s.
  - ovf = signed overflow = C[WIDTH-1] ^ C[WIDTH-2], i.e. carry into MSB xor carry out.
  - Reset value 0. Held under backpressure like s.
- When undefined: no ovf port and no extra registers.

Decomposition:
- Package skadd_pkg holds:
  - clog2 function
  - localparam derivations for LOG2W, NBANK, NSTG
  - typedef of the (G,P) pair struct
- Sub-module sklansky_level: one combinational prefix level, parametrised by WIDTH and level index l, mapping a (G,P) vector to a (G,P) vector.
- The top level instantiates LOG2W levels via generate and places banks between them.

Test Plan:
- WIDTH=16, REG_EVERY=2 (NSTG=3), out_ready=1. Apply back-to-back:
  - 0x59DF+0xBCD6 ci0 -> 0x16B5 co1
  - 0xCF42+0x488D ci0 -> 0x17CF co1
  - 0xD53C+0xC1C0 ci1 -> 0x96FD co1
  - 0x1DF6+0xFD7A ci1 -> 0x1B71 co1
  - Required: results appear on 4 consecutive cycles, the first 3 cycles after the first accept.
- Backpressure: hold out_ready=0 after the first result.
  - out_valid stays 1 and s stays 0x16B5.
  - in_ready drops once all 3 stages are full.
  - Release out_ready: remaining results emerge in order, none lost or duplicated.
- Carry chain, 0xFFFF+0x0000 ci1 -> s=0x0000, co=1. Also 0x0000+0x0000 ci0 -> 0x0000, co=0.
- SKADD_OVF_EN checks:
  - 0x7FFF+0x0001 ci0 -> s=0x8000, co0, ovf1
  - 0xD53C+0xC1C0 ci1 -> ovf0
  - 0x8000+0x8000 ci0 -> s=0x0000, co1, ovf1
- Reset mid-operation: assert rst_n=0 with 2 results in flight.
  - out_valid=0 and s=0 immediately, asynchronously.
  - After deassertion: no output until a new accept, then correct latency.
- Sweep WIDTH in {4,32,64} × REG_EVERY in {1,LOG2W}, with 1000 random operands and random out_ready each.
  - Scoreboard against a+b+ci.
  - Latency check: NSTG cycles when out_ready=1.
